// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LD_ACC = 2'd1,
    LD_ACK = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_STARVE_LIMIT = 8;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the MEM stage (default owner) and the loader.
// Optional loader anti-starvation guard: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  stall_o,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_ack,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  arb_state_t            state;
  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic                  force_grant;
  logic                  ld_grant;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  // Counts IDLE cycles in which the loader lost to the core; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (ld_grant)
        starve_cnt <= '0;
      else if (core_req && ld_req && (starve_cnt != CNT_W'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_grant = (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
  assign force_grant = 1'b0;
`endif

  assign ld_grant   = (state == IDLE) && ld_req && (!core_req || force_grant);
  assign core_rdata = mem_rd;

  always_comb begin
    mem_addr = core_addr;
    mem_wd   = core_wdata;
    mem_we   = core_req && core_we;
    stall_o  = 1'b0;
    ld_ack   = 1'b0;
    case (state)
      LD_ACC: begin
        mem_addr = cap_addr;
        mem_wd   = cap_wdata;
        mem_we   = cap_we;
        stall_o  = core_req;
      end
      LD_ACK: ld_ack = 1'b1;
      default: begin
        // A forced loader grant steals the port from a requesting core for this cycle.
        if (force_grant && ld_req && core_req) begin
          mem_we  = 1'b0;
          stall_o = 1'b1;
        end
      end
    endcase
    if (rst) begin
      mem_we  = 1'b0;
      stall_o = 1'b0;
      ld_ack  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= ld_grant ? LD_ACC : IDLE;
        LD_ACC:  state <= LD_ACK;
        default: state <= IDLE;
      endcase
    end
  end

  // Loader request is frozen at grant; later changes on the loader inputs are ignored.
  always_ff @(posedge clk) begin
    if (ld_grant) begin
      cap_we    <= ld_we;
      cap_addr  <= ld_addr;
      cap_wdata <= ld_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ld_rdata <= '0;
    else if (state == LD_ACC)
      ld_rdata <= mem_rd;
  end

endmodule
